// File: rtl/rf_wb_scheduler.sv
// ---------------------------------------------------------------------------
// rf_wb_scheduler
// Sequences the single write port of a 32x32 register file.
//  - Round-robin arbitration between the ALU writeback (wb0) and the
//    load/memory writeback (wb1).
//  - One registered commit cycle per accepted writeback (rf_we/rf_waddr/
//    rf_wdata); the register file itself writes on the falling edge inside
//    that cycle.
//  - Busy scoreboard of registers with an outstanding writeback, used by
//    decode to stall on RAW (stall_a/stall_b) and WAW (iss_ready) hazards.
//  - Sticky err_spurious flag for writebacks to registers that are not busy.
//    It is quiet for the two cycles after a flush, because in-flight results
//    may still land on registers the flush has just released.
// Optional build macro: RF_WB_BYPASS_EN
//  - Defined: a source register being committed this cycle does not stall,
//    since the falling-edge write makes it readable in the second half of
//    the commit cycle.
//  - Undefined: the stall drops one cycle after the commit cycle.
// ---------------------------------------------------------------------------
module rf_wb_scheduler #(
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   // issue interface
   input  logic          iss_valid,
   input  logic [AW-1:0] iss_rd,
   output logic          iss_ready,
   // decode source hazard lookup
   input  logic [AW-1:0] ra,
   input  logic [AW-1:0] rb,
   output logic          stall_a,
   output logic          stall_b,
   // ALU writeback
   input  logic          wb0_valid,
   input  logic [AW-1:0] wb0_rd,
   input  logic [DW-1:0] wb0_data,
   output logic          wb0_ready,
   // load writeback
   input  logic          wb1_valid,
   input  logic [AW-1:0] wb1_rd,
   input  logic [DW-1:0] wb1_data,
   output logic          wb1_ready,
   // register file write port
   output logic          rf_we,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   // error flag
   output logic          err_spurious
);

   // Round-robin preference: which source wins when both are valid.
   typedef enum logic {
      PREF_WB0 = 1'b0,
      PREF_WB1 = 1'b1
   } pref_t;

   pref_t           r_rr_ptr;
   logic [NREG-1:0] r_busy;
   logic [1:0]      r_quiet;
   logic            r_err;
   logic            r_we;
   logic [AW-1:0]   r_waddr;
   logic [DW-1:0]   r_wdata;

   logic            w_contend;
   logic            w_grant0;
   logic            w_grant1;
   logic            w_acc_valid;
   logic [AW-1:0]   w_acc_rd;
   logic [DW-1:0]   w_acc_data;
   logic            w_iss_acc;
   logic            w_spurious;
   logic            w_byp_a;
   logic            w_byp_b;
   logic [NREG-1:0] w_busy_next;

   // Arbitration: a lone valid source wins, a contended cycle follows rr_ptr.
   always_comb begin
      w_contend = wb0_valid & wb1_valid;
      w_grant0  = 1'b0;
      w_grant1  = 1'b0;
      if (w_contend) begin
         if (r_rr_ptr == PREF_WB0) begin
            w_grant0 = 1'b1;
         end else begin
            w_grant1 = 1'b1;
         end
      end else begin
         w_grant0 = wb0_valid;
         w_grant1 = wb1_valid;
      end
   end

   // Select the rd/data of the accepted writeback (if any).
   always_comb begin
      w_acc_valid = 1'b0;
      w_acc_rd    = '0;
      w_acc_data  = '0;
      case ({w_grant1, w_grant0})
         2'b01: begin
            w_acc_valid = 1'b1;
            w_acc_rd    = wb0_rd;
            w_acc_data  = wb0_data;
         end
         2'b10: begin
            w_acc_valid = 1'b1;
            w_acc_rd    = wb1_rd;
            w_acc_data  = wb1_data;
         end
         default: begin
            w_acc_valid = 1'b0;
            w_acc_rd    = '0;
            w_acc_data  = '0;
         end
      endcase
   end

   // Issue handshake and spurious-writeback detection.
   always_comb begin
      w_iss_acc  = iss_valid & ~r_busy[iss_rd];
      w_spurious = 1'b0;
      if (w_acc_valid && (w_acc_rd != '0) && !r_busy[w_acc_rd] &&
          !flush && (r_quiet == 2'd0)) begin
         w_spurious = 1'b1;
      end else begin
         w_spurious = 1'b0;
      end
   end

   // Next scoreboard: commit clears, issue sets (set wins), flush clears all.
   always_comb begin
      w_busy_next = r_busy;
      if (flush) begin
         w_busy_next = '0;
      end else begin
         if (r_we) begin
            w_busy_next[r_waddr] = 1'b0;
         end else begin
            w_busy_next = w_busy_next;
         end
         if (w_iss_acc) begin
            w_busy_next[iss_rd] = 1'b1;
         end else begin
            w_busy_next = w_busy_next;
         end
      end
      w_busy_next[0] = 1'b0;
   end

   // Bypass match: the register being committed right now.
`ifdef RF_WB_BYPASS_EN
   always_comb begin
      w_byp_a = r_we & (r_waddr == ra);
      w_byp_b = r_we & (r_waddr == rb);
   end
`else
   always_comb begin
      w_byp_a = 1'b0;
      w_byp_b = 1'b0;
   end
`endif

   assign wb0_ready    = w_grant0;
   assign wb1_ready    = w_grant1;
   assign iss_ready    = ~r_busy[iss_rd];
   assign stall_a      = r_busy[ra] & ~w_byp_a;
   assign stall_b      = r_busy[rb] & ~w_byp_b;
   assign rf_we        = r_we;
   assign rf_waddr     = r_waddr;
   assign rf_wdata     = r_wdata;
   assign err_spurious = r_err;

   // Round-robin pointer: flips to the other source after a contended grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr <= PREF_WB0;
      end else begin
         case (r_rr_ptr)
            PREF_WB0: r_rr_ptr <= w_contend ? PREF_WB1 : PREF_WB0;
            PREF_WB1: r_rr_ptr <= w_contend ? PREF_WB0 : PREF_WB1;
            default:  r_rr_ptr <= PREF_WB0;
         endcase
      end
   end

   // Scoreboard register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_next;
      end
   end

   // Commit stage: one write-port cycle per accepted nonzero-rd writeback.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         if (w_acc_valid) begin
            r_we    <= (w_acc_rd != '0);
            r_waddr <= w_acc_rd;
            r_wdata <= w_acc_data;
         end else begin
            r_we    <= 1'b0;
         end
      end
   end

   // Sticky error flag and the post-flush quiet window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err   <= 1'b0;
         r_quiet <= 2'd0;
      end else begin
         if (w_spurious) begin
            r_err <= 1'b1;
         end else begin
            r_err <= r_err;
         end
         if (flush) begin
            r_quiet <= 2'd2;
         end else if (r_quiet != 2'd0) begin
            r_quiet <= r_quiet - 2'd1;
         end else begin
            r_quiet <= 2'd0;
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for rf_wb_scheduler: directed vector table, a reset-in-flight
// sequence and randomized traffic against a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_rf_wb_scheduler;

   logic        clk = 1'b0;
   logic        rst, flush, iss_valid;
   logic [4:0]  iss_rd, ra, rb;
   logic        iss_ready, stall_a, stall_b;
   logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
   logic [4:0]  wb0_rd, wb1_rd;
   logic [31:0] wb0_data, wb1_data;
   logic        rf_we, err_spurious;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

`ifdef RF_WB_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif
   localparam logic NB = ~BYP;

   rf_wb_scheduler dut (
      .clk(clk), .rst(rst), .flush(flush),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
      .ra(ra), .rb(rb), .stall_a(stall_a), .stall_b(stall_b),
      .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
      .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .err_spurious(err_spurious)
   );

   always #5 clk = ~clk;

   int cnt_run  = 0;
   int cnt_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      cnt_run++;
      if (act !== exp) begin
         cnt_fail++;
         if (cnt_fail <= 40)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        iv;  logic [4:0] ird; logic [4:0] ra; logic [4:0] rb;
      logic        v0;  logic [4:0] rd0; logic [31:0] d0;
      logic        v1;  logic [4:0] rd1; logic [31:0] d1;
      logic        fl;
      logic        e_ready; logic e_sa; logic e_sb; logic e_r0; logic e_r1;
      logic        e_we; logic [4:0] e_addr; logic [31:0] e_data; logic e_err;
   } vec_t;

   localparam int NV = 19;
   vec_t tbl [NV];

   // ---------------- reference model ----------------
   bit          m_busy [32];
   bit          m_pref;      // 0: wb0 wins a tie, 1: wb1 wins
   bit          m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   bit          m_err;
   int          m_quiet;
   int          m_win;

   task automatic model_reset();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_pref = 0; m_we = 0; m_addr = '0; m_data = '0; m_err = 0; m_quiet = 0; m_win = -1;
   endtask

   function automatic logic [4:0] pick_busy();
      int q[$];
      foreach (m_busy[i]) if (m_busy[i]) q.push_back(i);
      if (q.size() == 0) return 5'd0;
      return 5'(q[$urandom_range(0, q.size() - 1)]);
   endfunction

   // One clock cycle of checking against the model; inputs already driven.
   task automatic tick();
      int          win;
      logic [4:0]  a_rd;
      logic [31:0] a_d;
      bit          old_busy [32];
      bit          e_sa, e_sb;
      #4;
      if (wb0_valid && wb1_valid) win = m_pref ? 1 : 0;
      else if (wb0_valid)         win = 0;
      else if (wb1_valid)         win = 1;
      else                        win = -1;
      e_sa = m_busy[ra] && !(BYP && m_we && (m_addr == ra));
      e_sb = m_busy[rb] && !(BYP && m_we && (m_addr == rb));
      chk("rnd_iss_ready", 32'(iss_ready), 32'(!m_busy[iss_rd]));
      chk("rnd_stall_a",   32'(stall_a),   32'(e_sa));
      chk("rnd_stall_b",   32'(stall_b),   32'(e_sb));
      chk("rnd_wb0_ready", 32'(wb0_ready), 32'(win == 0));
      chk("rnd_wb1_ready", 32'(wb1_ready), 32'(win == 1));
      @(posedge clk);
      old_busy = m_busy;
      a_rd = (win == 0) ? wb0_rd   : wb1_rd;
      a_d  = (win == 0) ? wb0_data : wb1_data;
      if (win >= 0 && a_rd != 0 && !old_busy[a_rd] && !flush && m_quiet == 0) m_err = 1;
      if (flush) begin
         foreach (m_busy[i]) m_busy[i] = 1'b0;
      end else begin
         if (m_we) m_busy[m_addr] = 1'b0;
         if (iss_valid && iss_rd != 0 && !old_busy[iss_rd]) m_busy[iss_rd] = 1'b1;
      end
      m_quiet = flush ? 2 : ((m_quiet > 0) ? m_quiet - 1 : 0);
      if (wb0_valid && wb1_valid) m_pref = !m_pref;
      m_we = (win >= 0) && (a_rd != 0);
      if (m_we) begin m_addr = a_rd; m_data = a_d; end
      m_win = win;
      #1;
      chk("rnd_rf_we", 32'(rf_we),        32'(m_we));
      chk("rnd_err",   32'(err_spurious), 32'(m_err));
      if (m_we) begin
         chk("rnd_waddr", 32'(rf_waddr), 32'(m_addr));
         chk("rnd_wdata", rf_wdata, m_data);
      end
   endtask

   initial begin
      //          iv    ird    ra     rb     v0    rd0    d0            v1    rd1    d1            fl    rdy   sa    sb    r0    r1    we    addr   data          err
      tbl[0]  = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0};
      tbl[1]  = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0};
      tbl[2]  = '{1'b0, 5'd0,  5'd5,  5'd0,  1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0};
      tbl[3]  = '{1'b0, 5'd0,  5'd5,  5'd5,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, NB,   NB,   1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0};
      tbl[4]  = '{1'b1, 5'd3,  5'd5,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0};
      tbl[5]  = '{1'b1, 5'd4,  5'd3,  5'd4,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0};
      tbl[6]  = '{1'b1, 5'd6,  5'd3,  5'd4,  1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,       1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3,  32'h11,       1'b0};
      tbl[7]  = '{1'b0, 5'd0,  5'd3,  5'd4,  1'b1, 5'd6,  32'h33,       1'b1, 5'd4,  32'h22,       1'b0, 1'b1, NB,   1'b1, 1'b0, 1'b1, 1'b1, 5'd4,  32'h22,       1'b0};
      tbl[8]  = '{1'b0, 5'd0,  5'd3,  5'd6,  1'b1, 5'd6,  32'h33,       1'b1, 5'd0,  32'h44,       1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6,  32'h33,       1'b0};
      tbl[9]  = '{1'b0, 5'd0,  5'd6,  5'd0,  1'b0, 5'd6,  32'h33,       1'b1, 5'd0,  32'h44,       1'b0, 1'b1, NB,   1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0};
      tbl[10] = '{1'b1, 5'd7,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0};
      tbl[11] = '{1'b1, 5'd8,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0};
      tbl[12] = '{1'b1, 5'd10, 5'd7,  5'd8,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0};
      tbl[13] = '{1'b0, 5'd7,  5'd10, 5'd8,  1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h77,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  32'h77,       1'b0};
      tbl[14] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 5'd0,  32'h55,       1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0};
      tbl[15] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0};
      tbl[16] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 5'd9,  32'hCAFEF00D, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9,  32'hCAFEF00D, 1'b1};
      tbl[17] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1};
      tbl[18] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1};

      // ---- reset state ----
      rst = 1'b1; flush = 1'b0; iss_valid = 1'b0; iss_rd = '0; ra = '0; rb = '0;
      wb0_valid = 1'b0; wb0_rd = '0; wb0_data = '0;
      wb1_valid = 1'b0; wb1_rd = '0; wb1_data = '0;
      #3;
      chk("reset_rf_we",  32'(rf_we), 32'd0);
      chk("reset_waddr",  32'(rf_waddr), 32'd0);
      chk("reset_wdata",  rf_wdata, 32'd0);
      chk("reset_err",    32'(err_spurious), 32'd0);
      chk("reset_ready",  32'(iss_ready), 32'd1);
      chk("reset_stall",  32'({stall_a, stall_b}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // ---- directed vector table ----
      for (int i = 0; i < NV; i++) begin
         iss_valid = tbl[i].iv; iss_rd = tbl[i].ird; ra = tbl[i].ra; rb = tbl[i].rb;
         wb0_valid = tbl[i].v0; wb0_rd = tbl[i].rd0; wb0_data = tbl[i].d0;
         wb1_valid = tbl[i].v1; wb1_rd = tbl[i].rd1; wb1_data = tbl[i].d1;
         flush = tbl[i].fl;
         #4;
         chk($sformatf("v%0d_iss_ready", i), 32'(iss_ready), 32'(tbl[i].e_ready));
         chk($sformatf("v%0d_stall_a", i),   32'(stall_a),   32'(tbl[i].e_sa));
         chk($sformatf("v%0d_stall_b", i),   32'(stall_b),   32'(tbl[i].e_sb));
         chk($sformatf("v%0d_wb0_ready", i), 32'(wb0_ready), 32'(tbl[i].e_r0));
         chk($sformatf("v%0d_wb1_ready", i), 32'(wb1_ready), 32'(tbl[i].e_r1));
         @(posedge clk); #1;
         chk($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(tbl[i].e_we));
         chk($sformatf("v%0d_err", i),   32'(err_spurious), 32'(tbl[i].e_err));
         if (tbl[i].e_we) begin
            chk($sformatf("v%0d_waddr", i), 32'(rf_waddr), 32'(tbl[i].e_addr));
            chk($sformatf("v%0d_wdata", i), rf_wdata, tbl[i].e_data);
         end
      end
      iss_valid = 1'b0; wb0_valid = 1'b0; wb1_valid = 1'b0; flush = 1'b0;

      // ---- reset asserted while a commit is in progress and a grant pending ----
      iss_valid = 1'b1; iss_rd = 5'd12; ra = 5'd0; rb = 5'd0;
      @(posedge clk); #1;
      iss_valid = 1'b0; iss_rd = 5'd12;
      wb0_valid = 1'b1; wb0_rd = 5'd12; wb0_data = 32'hABCD1234;
      @(posedge clk); #1;
      chk("rst_pre_rf_we", 32'(rf_we), 32'd1);
      wb0_valid = 1'b0;
      wb1_valid = 1'b1; wb1_rd = 5'd13; wb1_data = 32'h13131313; ra = 5'd12;
      #3;
      rst = 1'b1;
      #1;
      chk("rst_async_rf_we", 32'(rf_we), 32'd0);
      chk("rst_async_waddr", 32'(rf_waddr), 32'd0);
      chk("rst_async_wdata", rf_wdata, 32'd0);
      chk("rst_async_err",   32'(err_spurious), 32'd0);
      chk("rst_async_stall", 32'(stall_a), 32'd0);
      @(posedge clk); #1;
      chk("rst_hold_rf_we", 32'(rf_we), 32'd0);
      rst = 1'b0; wb1_valid = 1'b0; ra = 5'd0;
      model_reset();

      // ---- randomized traffic against the reference model ----
      for (int c = 0; c < 1500; c++) begin
         flush     = ($urandom_range(0, 39) == 0);
         iss_valid = 1'($urandom_range(0, 1));
         iss_rd    = 5'($urandom_range(0, 31));
         ra        = $urandom_range(0, 1) ? pick_busy() : 5'($urandom_range(0, 31));
         rb        = $urandom_range(0, 1) ? pick_busy() : 5'($urandom_range(0, 31));
         if (!wb0_valid && $urandom_range(0, 1) == 1) begin
            wb0_valid = 1'b1;
            wb0_rd    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : pick_busy();
            wb0_data  = $urandom;
         end
         if (!wb1_valid && $urandom_range(0, 1) == 1) begin
            wb1_valid = 1'b1;
            wb1_rd    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : pick_busy();
            wb1_data  = $urandom;
         end
         tick();
         if (m_win == 0) wb0_valid = 1'b0;
         if (m_win == 1) wb1_valid = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", cnt_run, cnt_fail);
      $finish;
   end

endmodule
